// File: rtl/fir_stream_chain.sv
// rtl/fir_stream_chain.sv - fixed-pattern sample source streaming into an N-tap symmetric FIR
// Source plays XL samples once per reset; the FIR registers products, then the full-precision sum.
module fir_stream_chain #(
  parameter int N       = 20,
  parameter int W_IN    = 37,
  parameter int W_IN_F  = 14,
  parameter int W_COEF  = 16,
  parameter int W_OUT   = W_IN + N,
  parameter int XL      = 148,
  parameter int PATTERN = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  output logic [W_OUT-1:0] out_data,
  output logic             out_valid,
  output logic             dbg_tvalid,
  output logic             dbg_tready,
  output logic [W_IN-1:0]  dbg_tdata
);
  localparam int IDX_W = $clog2(XL);
  localparam int W_P   = W_IN + W_COEF;
  localparam int W_ACC = W_P + $clog2(N);
  localparam int W_S   = (W_ACC > W_OUT) ? W_ACC : W_OUT;

  typedef enum logic [1:0] {SRC_IDLE, SRC_RUN, SRC_DONE} src_state_t;

  src_state_t             src_state_q, src_state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   tvalid_q, tvalid_d;
  logic [W_IN-1:0]        tdata_q, tdata_d;
  logic                   tready;
  logic                   accept;

  logic signed [W_IN-1:0] dly_q  [N];
  logic signed [W_IN-1:0] dly_d  [N];
  logic signed [W_P-1:0]  prod_q [N];
  logic signed [W_P-1:0]  prod_d [N];
  logic                   v0_q, v0_d, v1_q, v1_d;
  logic                   out_valid_q, out_valid_d;
  logic [W_OUT-1:0]       out_data_q, out_data_d;
  logic signed [W_S-1:0]  sum;

  function automatic logic [W_IN-1:0] sample(input logic [IDX_W-1:0] k);
    sample = '0;
    if (PATTERN == 1 || k == '0) sample[W_IN_F] = 1'b1;
  endfunction

  function automatic logic signed [W_COEF-1:0] coef(input int i);
    return (i < N / 2) ? W_COEF'(i + 1) : W_COEF'(N - i);
  endfunction

  assign tready = resetn & ~flush;
  assign accept = tvalid_q & tready;

  always_comb begin
    src_state_d = src_state_q;
    idx_d       = idx_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    case (src_state_q)
      SRC_IDLE: begin
        src_state_d = SRC_RUN;
        tvalid_d    = 1'b1;
        tdata_d     = sample(idx_q);
      end
      SRC_RUN: begin
        if (accept) begin
          if (idx_q == IDX_W'(XL - 1)) begin
            src_state_d = SRC_DONE;
            tvalid_d    = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tdata_d = sample(idx_q + IDX_W'(1));
          end
        end
      end
      default: ;
    endcase
  end

  // Products are taken from the already-shifted line, giving accept -> product -> sum.
  always_comb begin
    dly_d       = dly_q;
    v0_d        = accept;
    v1_d        = v0_q;
    out_valid_d = v1_q;
    out_data_d  = v1_q ? W_OUT'(sum) : out_data_q;
    for (int i = 0; i < N; i++) begin
      prod_d[i] = W_P'(dly_q[i]) * W_P'(coef(i));
    end
    if (accept) begin
      dly_d[0] = tdata_q;
      for (int i = 1; i < N; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        dly_d[i] = '0;
      end
      v0_d        = 1'b0;
      v1_d        = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + W_S'(prod_q[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_state_q <= SRC_IDLE;
      idx_q       <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      for (int i = 0; i < N; i++) begin
        dly_q[i]  <= '0;
        prod_q[i] <= '0;
      end
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      src_state_q <= src_state_d;
      idx_q       <= idx_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      for (int i = 0; i < N; i++) begin
        dly_q[i]  <= dly_d[i];
        prod_q[i] <= prod_d[i];
      end
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign dbg_tvalid = tvalid_q;
  assign dbg_tready = tready;
  assign dbg_tdata  = tdata_q;

endmodule

// File: tb/tb_fir_stream_chain.sv
// tb/tb_fir_stream_chain.sv - bench for fir_stream_chain, impulse and step instances side by side
// A history-based model predicts every output and its arrival cycle; tables and sequences cover corners.
module tb_fir_stream_chain;
  localparam int N  = 20;
  localparam int XL = 148;

  logic        clk = 1'b0;
  logic        resetn, fl0, fl1;
  logic [56:0] od0, od1;
  logic        ov0, ov1, tv0, tv1, tr0, tr1;
  logic [36:0] td0, td1;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int bad;
  logic [36:0] held;

  longint hist [2][256];
  int     hcnt [2];
  longint expv [2][256];
  int     expt [2][256];
  int     eh [2], et [2];
  int     n_acc [2], n_out [2];
  int     first_acc [2], first_out [2];
  longint capv [2][256];

  typedef struct {
    int     dut;
    int     idx;
    longint exp;
  } vec_t;
  vec_t tab [12];

  fir_stream_chain #(.PATTERN(0)) u_imp (
    .clk(clk), .resetn(resetn), .flush(fl0), .out_data(od0), .out_valid(ov0),
    .dbg_tvalid(tv0), .dbg_tready(tr0), .dbg_tdata(td0)
  );
  fir_stream_chain #(.PATTERN(1)) u_step (
    .clk(clk), .resetn(resetn), .flush(fl1), .out_data(od1), .out_valid(ov1),
    .dbg_tvalid(tv1), .dbg_tready(tr1), .dbg_tdata(td1)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic longint hcoef(input int i);
    return (i < N / 2) ? longint'(i + 1) : longint'(N - i);
  endfunction

  function automatic longint src_x(input int d, input int k);
    return (d == 1 || k == 0) ? longint'(16384) : longint'(0);
  endfunction

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called at each falling edge: what is visible now happens or was produced at the neighbouring rising edge.
  task automatic monitor_dut(input int d, input logic v, input logic tv, input logic tr,
                             input logic fl, input longint o, input longint tdv);
    longint y;
    if (!resetn) begin
      n_acc[d] = 0; n_out[d] = 0; eh[d] = 0; et[d] = 0; hcnt[d] = 0;
      first_acc[d] = -1; first_out[d] = -1;
      return;
    end
    while (eh[d] != et[d] && expt[d][eh[d]] < cyc) begin
      chk(1'b0, "missing_out", 0, expv[d][eh[d]]);
      eh[d]++;
    end
    if (v) begin
      if (eh[d] == et[d]) chk(1'b0, "spurious_out", o, 0);
      else begin
        chk(expt[d][eh[d]] == cyc && expv[d][eh[d]] == o, "out_data", o, expv[d][eh[d]]);
        eh[d]++;
      end
      if (first_out[d] < 0) first_out[d] = cyc;
      if (n_out[d] < 256) capv[d][n_out[d]] = o;
      n_out[d]++;
    end
    if (fl) begin
      while (et[d] != eh[d] && expt[d][et[d]-1] >= cyc + 1) et[d]--;
      hcnt[d] = 0;
    end else if (tv && tr) begin
      chk(n_acc[d] < XL, "extra_accept", n_acc[d], XL - 1);
      chk(tdv == src_x(d, n_acc[d]), "src_tdata", tdv, src_x(d, n_acc[d]));
      if (first_acc[d] < 0) first_acc[d] = cyc;
      if (hcnt[d] < 256 && et[d] < 256) begin
        hist[d][hcnt[d]] = tdv;
        hcnt[d]++;
        y = 0;
        for (int i = 0; i < N && i < hcnt[d]; i++) y += hcoef(i) * hist[d][hcnt[d]-1-i];
        expv[d][et[d]] = y;
        expt[d][et[d]] = cyc + 3;
        et[d]++;
      end
      n_acc[d]++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor_dut(0, ov0, tv0, tr0, fl0, longint'($signed(od0)), longint'(td0));
    monitor_dut(1, ov1, tv1, tr1, fl1, longint'($signed(od1)), longint'(td1));
  end

  task automatic do_reset();
    @(posedge clk);
    #1 resetn = 1'b0;
    fl0 = 1'b0;
    fl1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic wait_acc(input int d, input int target);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (n_acc[d] >= target) break;
    end
    chk(n_acc[d] >= target, "wait_accepts", n_acc[d], target);
  endtask

  initial begin
    resetn = 1'b0;
    fl0 = 1'b0;
    fl1 = 1'b0;
    tab[0]  = '{0, 0,   16384};
    tab[1]  = '{0, 9,   163840};
    tab[2]  = '{0, 10,  163840};
    tab[3]  = '{0, 19,  16384};
    tab[4]  = '{0, 20,  0};
    tab[5]  = '{0, 147, 0};
    tab[6]  = '{1, 0,   16384};
    tab[7]  = '{1, 1,   49152};
    tab[8]  = '{1, 2,   98304};
    tab[9]  = '{1, 9,   901120};
    tab[10] = '{1, 19,  1802240};
    tab[11] = '{1, 147, 1802240};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(!ov0 && !ov1, "rst_out_valid", {ov1, ov0}, 0);
    chk(!tv0 && !tv1, "rst_tvalid", {tv1, tv0}, 0);
    chk(!tr0 && !tr1, "rst_tready", {tr1, tr0}, 0);
    chk(od0 == 0 && od1 == 0, "rst_out_data", longint'(od0 | od1), 0);
    chk(td0 == 0 && td1 == 0, "rst_tdata", longint'(td0 | td1), 0);

    // Free-running impulse and step
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(n_out[d] == XL, "out_count", n_out[d], XL);
      chk(n_acc[d] == XL, "accept_count", n_acc[d], XL);
      chk(first_out[d] - first_acc[d] == 3, "first_latency", first_out[d] - first_acc[d], 3);
    end
    for (int k = 0; k < 12; k++)
      chk(capv[tab[k].dut][tab[k].idx] == tab[k].exp, "vec_out", capv[tab[k].dut][tab[k].idx], tab[k].exp);

    // Idle after stream end
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tv0 || tv1 || ov0 || ov1 || longint'($signed(od0)) != capv[0][XL-1] ||
          longint'($signed(od1)) != capv[1][XL-1]) bad++;
    end
    chk(bad == 0, "post_end_idle", bad, 0);

    // Flush for 5 cycles after 50 accepts on the step instance
    do_reset();
    wait_acc(1, 50);
    fl1 = 1'b1;
    held = td1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tr1 || td1 != held) bad++;
      @(posedge clk);
    end
    #1 fl1 = 1'b0;
    chk(bad == 0, "flush_stall", bad, 0);
    repeat (250) @(posedge clk);
    #1;
    chk(n_out[1] == XL - 2, "flush_out_count", n_out[1], XL - 2);
    chk(n_acc[1] == XL, "flush_accept_count", n_acc[1], XL);
    chk(n_out[0] == XL, "noflush_out_count", n_out[0], XL);
    chk(capv[1][47] == 1802240, "pre_flush_out", capv[1][47], 1802240);
    chk(capv[1][48] == 16384, "ramp_restart0", capv[1][48], 16384);
    chk(capv[1][49] == 49152, "ramp_restart1", capv[1][49], 49152);

    // Asynchronous reset mid-cycle after 100 samples
    do_reset();
    wait_acc(1, 100);
    #2 resetn = 1'b0;
    #1;
    chk(!ov0 && !ov1, "async_rst_valid", {ov1, ov0}, 0);
    chk(!tv0 && !tv1, "async_rst_tvalid", {tv1, tv0}, 0);
    chk(od0 == 0 && od1 == 0, "async_rst_data", longint'(od0 | od1), 0);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk(n_out[0] == XL && n_out[1] == XL, "replay_count", n_out[0] + n_out[1], 2 * XL);
    chk(capv[0][0] == 16384 && capv[1][0] == 16384, "replay_first", capv[1][0], 16384);

    // Toggled flush on step, random flush on impulse
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      fl1 = i[0];
      fl0 = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
      if (n_acc[0] >= XL && n_acc[1] >= XL) break;
    end
    fl0 = 1'b0;
    fl1 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk(n_acc[1] == XL, "toggle_accepts", n_acc[1], XL);
    chk(n_acc[0] == XL, "random_accepts", n_acc[0], XL);
    chk(!tv0 && !tv1, "toggle_src_done", {tv1, tv0}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
